uart_tx_arbiter: RTL

//  Shares one uart_fsm transmitter between NUM_REQ byte sources (button char sender, FND echo, ...).

---
 rtl/uart_tx_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between byte sources
//
// Purpose:
//   Several byte sources (button char sender, FND echo, ...) share a single
//   uart_fsm transmitter. The arbiter picks a requester round-robin, latches its
//   byte, fires a one-cycle start pulse, waits for tx_done to rise and fall, then
//   acks the requester. A requester asserting req_hold keeps the transmitter for
//   back-to-back bytes, up to MAX_BURST bytes, before it must rotate.
//   A tx_done that never rises within TIMEOUT_CYC cycles drops the byte and
//   pulses err.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-low reset
//   req       in   [NUM_REQ]   per-requester byte request, held until ack
//   req_hold  in   [NUM_REQ]   keep the grant after this byte (burst)
//   req_data  in   [8*NUM_REQ] byte of requester i at [8*i+7:8*i]
//   grant     out  [NUM_REQ]   one-hot owner of the transmitter, 0 when idle
//   ack       out  [NUM_REQ]   one-cycle pulse when the owner's byte is sent
//   err       out  1           one-cycle pulse on tx_done timeout
//   tx_start  out  1           one-cycle start pulse to uart_fsm
//   tx_data   out  [8]         byte to uart_fsm, valid from tx_start until next latch
//   tx_done   in   1           uart_fsm completion level

module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_hold,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   err,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]         BURST_MAX = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_HI = 2'd1,
        S_WAIT_LO = 2'd2
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     winner_q;
    logic [7:0]           burst_cnt_q;
    logic [TMR_W-1:0]     timer_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 err_q;
    logic                 tx_start_q;
    logic [7:0]           tx_data_q;

    // Combinational round-robin pick for the next IDLE grant.
    logic                 win_valid_d;
    logic [IDX_W-1:0]     win_idx_d;
    logic [IDX_W-1:0]     cand_d;
    logic [7:0]           win_data_d;

    // Byte currently presented by the owner, used when a burst continues.
    logic [7:0]           own_data_d;
    logic                 burst_more_d;

    // Scan from the farthest candidate back to rr_ptr+1 so the nearest set
    // request after the pointer is the one left standing.
    always_comb begin
        win_valid_d = 1'b0;
        win_idx_d   = '0;
        cand_d      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_d = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req[cand_d]) begin
                win_valid_d = 1'b1;
                win_idx_d   = cand_d;
            end
        end
    end

    assign win_data_d   = req_data[8*win_idx_d +: 8];
    assign own_data_d   = req_data[8*winner_q +: 8];
    assign burst_more_d = req[winner_q] && req_hold[winner_q] && (burst_cnt_q < BURST_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            winner_q    <= '0;
            burst_cnt_q <= '0;
            timer_q     <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            // Pulses default low; each state raises them for exactly one cycle.
            ack_q      <= '0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // tx_done is deliberately not looked at here.
                    if (win_valid_d) begin
                        winner_q    <= win_idx_d;
                        grant_q     <= ONE_HOT0 << win_idx_d;
                        tx_data_q   <= win_data_d;
                        tx_start_q  <= 1'b1;
                        burst_cnt_q <= 8'd1;
                        timer_q     <= '0;
                        state_q     <= S_WAIT_HI;
                    end
                end

                S_WAIT_HI: begin
                    if (tx_done) begin
                        state_q <= S_WAIT_LO;
                    end else if (timer_q == TMR_LAST) begin
                        // Transmitter never answered: drop the byte, no ack.
                        err_q       <= 1'b1;
                        grant_q     <= '0;
                        rr_ptr_q    <= winner_q;
                        burst_cnt_q <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_WAIT_LO: begin
                    if (!tx_done) begin
                        ack_q <= grant_q;
                        if (burst_more_d) begin
                            // Back-to-back byte for the same owner, no IDLE gap.
                            tx_data_q   <= own_data_d;
                            tx_start_q  <= 1'b1;
                            burst_cnt_q <= burst_cnt_q + 8'd1;
                            timer_q     <= '0;
                            state_q     <= S_WAIT_HI;
                        end else begin
                            grant_q     <= '0;
                            rr_ptr_q    <= winner_q;
                            burst_cnt_q <= '0;
                            state_q     <= S_IDLE;
                        end
                    end
                end

                default: begin
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule
